// File: rtl/dac_link_rx_pkg.sv
// Shared definitions for the DAC serial link: header bytes, frame shape and
// receiver state encoding. Used by both the transmitter and the receiver.
package dac_link_rx_pkg;

  localparam logic [7:0] ADDR_BYTE_DEF = 8'h90;
  localparam logic [7:0] CTRL_BYTE_DEF = 8'h40;

  // Eight data slots followed by one ack slot per byte.
  localparam int         FRAME_SLOTS = 9;
  localparam logic [3:0] LAST_BIT    = 4'(FRAME_SLOTS - 2);
  localparam logic [3:0] ACK_SLOT    = 4'(FRAME_SLOTS - 1);

  localparam int                      SAMPLE_CNT_W   = 11;
  localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_CTRL  = 3'd2,
    ST_DATA  = 3'd3,
    ST_ERROR = 3'd4
  } link_state_e;

  function automatic logic [SAMPLE_CNT_W-1:0] sat_inc(input logic [SAMPLE_CNT_W-1:0] v);
    return (v == SAMPLE_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dac_link_rx_if.sv
// Bundle of the serial link lines plus the receiver's sample outputs.
// sample_valid is a one-cycle strobe with no backpressure: data is valid only in that cycle.
interface dac_link_rx_if;
  import dac_link_rx_pkg::*;

  logic                    scl;
  logic                    x;
  logic                    y;
  logic [7:0]              x_data;
  logic [7:0]              y_data;
  logic                    sample_valid;
  logic                    hdr_ok;
  logic                    hdr_err;
  logic [SAMPLE_CNT_W-1:0] sample_cnt;

  modport master (
    output scl, x, y,
    input  x_data, y_data, sample_valid, hdr_ok, hdr_err, sample_cnt
  );

  modport slave (
    input  scl, x, y,
    output x_data, y_data, sample_valid, hdr_ok, hdr_err, sample_cnt
  );

endinterface

// File: rtl/dac_link_rx_line_sync.sv
// Synchronizer plus history flop for one asynchronous line, with edge strobes.
// All flops preset to 1 so idle-high lines look quiet coming out of reset.
module line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic Not_Rst,
  input  logic i_line,
  output logic o_cur,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk) begin
    if (!Not_Rst) begin
      r_sync <= '1;
      r_hist <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_line};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_cur  = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_hist;
  assign o_fall = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/dac_link_rx.sv
// Two-lane serial DAC link receiver: checks a two-byte header on both lanes,
// then streams x/y data bytes out with a one-cycle sample strobe.
module dac_link_rx
  import dac_link_rx_pkg::*;
#(
  parameter logic [7:0] ADDR_BYTE   = ADDR_BYTE_DEF,
  parameter logic [7:0] CTRL_BYTE   = CTRL_BYTE_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    Not_Rst,
  input  logic                    scl,
  input  logic                    x,
  input  logic                    y,
  output logic [7:0]              x_data,
  output logic [7:0]              y_data,
  output logic                    sample_valid,
  output logic                    hdr_ok,
  output logic                    hdr_err,
  output logic [SAMPLE_CNT_W-1:0] sample_cnt
);

  logic w_scl_cur, w_scl_rise, w_scl_fall;
  logic w_x_cur, w_x_rise, w_x_fall;
  logic w_y_cur, w_y_rise, w_y_fall;
  logic w_unused_edges;

  line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .Not_Rst(Not_Rst), .i_line(scl),
    .o_cur(w_scl_cur), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  line_sync #(.STAGES(SYNC_STAGES)) u_x_sync (
    .clk(clk), .Not_Rst(Not_Rst), .i_line(x),
    .o_cur(w_x_cur), .o_rise(w_x_rise), .o_fall(w_x_fall)
  );

  line_sync #(.STAGES(SYNC_STAGES)) u_y_sync (
    .clk(clk), .Not_Rst(Not_Rst), .i_line(y),
    .o_cur(w_y_cur), .o_rise(w_y_rise), .o_fall(w_y_fall)
  );

  assign w_unused_edges = w_scl_fall | w_y_rise | w_y_fall;

  // scl high now and last cycle; an x edge on an scl rise is therefore never framing.
  logic w_scl_stable_hi, w_start, w_stop;
  assign w_scl_stable_hi = w_scl_cur & ~w_scl_rise;
  assign w_start         = w_x_fall & w_scl_stable_hi;
  assign w_stop          = w_x_rise & w_scl_stable_hi;

  link_state_e             r_state;
  logic [3:0]              r_bit_cnt;
  logic [7:0]              r_x_sh, r_y_sh;
  logic [7:0]              r_x_data, r_y_data;
  logic                    r_sample_valid, r_hdr_ok, r_hdr_err;
  logic [SAMPLE_CNT_W-1:0] r_sample_cnt;

  logic       w_active;
  logic [7:0] w_x_byte, w_y_byte;
  assign w_active = (r_state == ST_ADDR) || (r_state == ST_CTRL) || (r_state == ST_DATA);
  assign w_x_byte = {r_x_sh[6:0], w_x_cur};
  assign w_y_byte = {r_y_sh[6:0], w_y_cur};

  always_ff @(posedge clk) begin
    if (!Not_Rst) begin
      r_state        <= ST_IDLE;
      r_bit_cnt      <= 4'd0;
      r_x_sh         <= 8'd0;
      r_y_sh         <= 8'd0;
      r_x_data       <= 8'd0;
      r_y_data       <= 8'd0;
      r_sample_valid <= 1'b0;
      r_hdr_ok       <= 1'b0;
      r_hdr_err      <= 1'b0;
      r_sample_cnt   <= '0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_start) begin
        r_state      <= ST_ADDR;
        r_bit_cnt    <= 4'd0;
        r_sample_cnt <= '0;
        r_hdr_err    <= 1'b0;
        r_hdr_ok     <= 1'b0;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_hdr_ok <= 1'b0;
      end else if (w_scl_rise && w_active) begin
        if (r_bit_cnt == ACK_SLOT) begin
          r_bit_cnt <= 4'd0;
        end else begin
          r_x_sh    <= w_x_byte;
          r_y_sh    <= w_y_byte;
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == LAST_BIT) begin
            case (r_state)
              ST_ADDR: begin
                if (w_x_byte == ADDR_BYTE && w_y_byte == ADDR_BYTE) begin
                  r_state <= ST_CTRL;
                end else begin
                  r_state   <= ST_ERROR;
                  r_hdr_err <= 1'b1;
                end
              end
              ST_CTRL: begin
                if (w_x_byte == CTRL_BYTE && w_y_byte == CTRL_BYTE) begin
                  r_state  <= ST_DATA;
                  r_hdr_ok <= 1'b1;
                end else begin
                  r_state   <= ST_ERROR;
                  r_hdr_err <= 1'b1;
                end
              end
              ST_DATA: begin
                r_x_data       <= w_x_byte;
                r_y_data       <= w_y_byte;
                r_sample_valid <= 1'b1;
                r_sample_cnt   <= sat_inc(r_sample_cnt);
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign x_data       = r_x_data;
  assign y_data       = r_y_data;
  assign sample_valid = r_sample_valid;
  assign hdr_ok       = r_hdr_ok;
  assign hdr_err      = r_hdr_err;
  assign sample_cnt   = r_sample_cnt;

endmodule

// File: tb/tb_dac_link_rx.sv
// Directed bench for dac_link_rx: drives the link through the interface and
// checks outputs against hand-computed values.
module tb_dac_link_rx;
  import dac_link_rx_pkg::*;

  logic clk = 1'b0;
  logic Not_Rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   sv_count = 0;
  int   half = 3;

  dac_link_rx_if lnk();

  always #5 clk = ~clk;

  dac_link_rx #(.ADDR_BYTE(8'h90), .CTRL_BYTE(8'h40), .SYNC_STAGES(2)) dut (
    .clk(clk), .Not_Rst(Not_Rst),
    .scl(lnk.scl), .x(lnk.x), .y(lnk.y),
    .x_data(lnk.x_data), .y_data(lnk.y_data),
    .sample_valid(lnk.sample_valid), .hdr_ok(lnk.hdr_ok), .hdr_err(lnk.hdr_err),
    .sample_cnt(lnk.sample_cnt)
  );

  // Counts high cycles of the strobe, so a two-cycle pulse shows up as two.
  always @(negedge clk) if (lnk.sample_valid === 1'b1) sv_count++;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    lnk.scl = 1'b0; tick(half);
    lnk.x = 1'b1; lnk.y = 1'b1; tick(half);
    lnk.scl = 1'b1; tick(half);
    lnk.x = 1'b0; lnk.y = 1'b0; tick(half);
  endtask

  task automatic send_stop();
    lnk.scl = 1'b0; tick(half);
    lnk.x = 1'b0; lnk.y = 1'b0; tick(half);
    lnk.scl = 1'b1; tick(half);
    lnk.x = 1'b1; lnk.y = 1'b1; tick(half);
  endtask

  task automatic send_bit(input logic bx, input logic by);
    lnk.scl = 1'b0; lnk.x = bx; lnk.y = by; tick(half);
    lnk.scl = 1'b1; tick(half);
  endtask

  task automatic send_byte(input logic [7:0] bx, input logic [7:0] by);
    for (int i = 7; i >= 0; i--) send_bit(bx[i], by[i]);
    send_bit(1'b1, 1'b1);
  endtask

  task automatic send_header();
    send_start();
    send_byte(8'h90, 8'h90);
    send_byte(8'h40, 8'h40);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    lnk.scl = 1'b1; lnk.x = 1'b1; lnk.y = 1'b1;
    Not_Rst = 1'b0;
    tick(4);
    total++; if (lnk.x_data !== 8'h00) begin bad++; $display("FAIL rst_x_data got=%h exp=00", lnk.x_data); end
    total++; if (lnk.y_data !== 8'h00) begin bad++; $display("FAIL rst_y_data got=%h exp=00", lnk.y_data); end
    total++; if (lnk.sample_cnt !== 11'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", lnk.sample_cnt); end
    total++; if ({lnk.sample_valid, lnk.hdr_ok, lnk.hdr_err} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b exp=000", {lnk.sample_valid, lnk.hdr_ok, lnk.hdr_err});
    end
    Not_Rst = 1'b1;
    tick(10);
    total++; if ({lnk.hdr_ok, lnk.hdr_err} !== 2'b00 || sv_count != 0) begin
      bad++; $display("FAIL rst_idle got=%b/%0d exp=00/0", {lnk.hdr_ok, lnk.hdr_err}, sv_count);
    end
  endtask

  task automatic test_basic();
    int sv0;
    send_header();
    tick(4);
    total++; if (lnk.hdr_ok !== 1'b1) begin bad++; $display("FAIL basic_hdr_ok got=%b exp=1", lnk.hdr_ok); end
    sv0 = sv_count;
    send_byte(8'hA5, 8'h3C);
    tick(6);
    total++; if (sv_count - sv0 != 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", sv_count - sv0); end
    total++; if (lnk.x_data !== 8'hA5) begin bad++; $display("FAIL basic_x_data got=%h exp=a5", lnk.x_data); end
    total++; if (lnk.y_data !== 8'h3C) begin bad++; $display("FAIL basic_y_data got=%h exp=3c", lnk.y_data); end
    total++; if (lnk.sample_cnt !== 11'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", lnk.sample_cnt); end
    total++; if ({lnk.hdr_ok, lnk.hdr_err, lnk.sample_valid} !== 3'b100) begin
      bad++; $display("FAIL basic_flags got=%b exp=100", {lnk.hdr_ok, lnk.hdr_err, lnk.sample_valid});
    end
    send_byte(8'h5A, 8'hC3);
    tick(6);
    total++; if ({lnk.x_data, lnk.y_data} !== 16'h5AC3 || lnk.sample_cnt !== 11'd2) begin
      bad++; $display("FAIL basic_second got=%h/%0d exp=5ac3/2", {lnk.x_data, lnk.y_data}, lnk.sample_cnt);
    end
  endtask

  task automatic test_addr_err();
    int sv0;
    sv0 = sv_count;
    send_start();
    send_byte(8'h91, 8'h90);
    tick(4);
    total++; if ({lnk.hdr_err, lnk.hdr_ok} !== 2'b10) begin
      bad++; $display("FAIL addr_err_flags got=%b exp=10", {lnk.hdr_err, lnk.hdr_ok});
    end
    send_byte(8'h40, 8'h40);
    send_byte(8'h11, 8'h22);
    tick(6);
    total++; if (sv_count - sv0 != 0) begin bad++; $display("FAIL addr_err_pulses got=%0d exp=0", sv_count - sv0); end
    total++; if ({lnk.x_data, lnk.y_data} !== 16'h5AC3) begin
      bad++; $display("FAIL addr_err_held got=%h exp=5ac3", {lnk.x_data, lnk.y_data});
    end
    total++; if (lnk.sample_cnt !== 11'd0) begin bad++; $display("FAIL addr_err_cnt got=%0d exp=0", lnk.sample_cnt); end
    send_header();
    tick(4);
    total++; if ({lnk.hdr_err, lnk.hdr_ok} !== 2'b01) begin
      bad++; $display("FAIL addr_err_recover got=%b exp=01", {lnk.hdr_err, lnk.hdr_ok});
    end
    send_byte(8'h01, 8'h02);
    tick(6);
    total++; if ({lnk.x_data, lnk.y_data} !== 16'h0102 || lnk.sample_cnt !== 11'd1) begin
      bad++; $display("FAIL addr_err_data got=%h/%0d exp=0102/1", {lnk.x_data, lnk.y_data}, lnk.sample_cnt);
    end
  endtask

  task automatic test_ctrl_err();
    int sv0;
    sv0 = sv_count;
    send_start();
    send_byte(8'h90, 8'h90);
    send_byte(8'h40, 8'h41);
    send_byte(8'h77, 8'h77);
    tick(6);
    total++; if ({lnk.hdr_err, lnk.hdr_ok} !== 2'b10) begin
      bad++; $display("FAIL ctrl_err_flags got=%b exp=10", {lnk.hdr_err, lnk.hdr_ok});
    end
    total++; if (sv_count - sv0 != 0 || lnk.x_data !== 8'h01) begin
      bad++; $display("FAIL ctrl_err_nosample got=%0d/%h exp=0/01", sv_count - sv0, lnk.x_data);
    end
  endtask

  task automatic test_stop();
    int sv0;
    send_header();
    send_byte(8'hC8, 8'h17);
    send_stop();
    tick(4);
    total++; if (lnk.hdr_ok !== 1'b0) begin bad++; $display("FAIL stop_hdr_ok got=%b exp=0", lnk.hdr_ok); end
    sv0 = sv_count;
    for (int i = 0; i < 20; i++) send_bit(i[0], i[1]);
    lnk.scl = 1'b0; tick(half);
    lnk.x = 1'b1; lnk.y = 1'b1; tick(half);
    lnk.scl = 1'b1; tick(6);
    total++; if (sv_count - sv0 != 0) begin bad++; $display("FAIL stop_idle_pulses got=%0d exp=0", sv_count - sv0); end
    total++; if ({lnk.x_data, lnk.y_data} !== 16'hC817) begin
      bad++; $display("FAIL stop_held got=%h exp=c817", {lnk.x_data, lnk.y_data});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int sv0;
    v = 8'hF0;
    send_header();
    send_byte(8'h33, 8'h44);
    for (int i = 7; i >= 4; i--) send_bit(v[i], v[i]);
    Not_Rst = 1'b0;
    tick(2);
    total++; if ({lnk.x_data, lnk.y_data} !== 16'h0000 || lnk.sample_cnt !== 11'd0) begin
      bad++; $display("FAIL rmid_data got=%h/%0d exp=0000/0", {lnk.x_data, lnk.y_data}, lnk.sample_cnt);
    end
    total++; if ({lnk.sample_valid, lnk.hdr_ok, lnk.hdr_err} !== 3'b000) begin
      bad++; $display("FAIL rmid_flags got=%b exp=000", {lnk.sample_valid, lnk.hdr_ok, lnk.hdr_err});
    end
    Not_Rst = 1'b1;
    sv0 = sv_count;
    for (int i = 3; i >= 0; i--) send_bit(v[i], v[i]);
    send_bit(1'b1, 1'b1);
    send_byte(8'h55, 8'h55);
    send_byte(8'hAA, 8'hAA);
    tick(6);
    total++; if (sv_count - sv0 != 0 || lnk.sample_cnt !== 11'd0 || lnk.hdr_ok !== 1'b0) begin
      bad++; $display("FAIL rmid_abandon got=%0d/%0d/%b exp=0/0/0", sv_count - sv0, lnk.sample_cnt, lnk.hdr_ok);
    end
    send_header();
    send_byte(8'h66, 8'h99);
    tick(6);
    total++; if ({lnk.x_data, lnk.y_data} !== 16'h6699 || lnk.sample_cnt !== 11'd1) begin
      bad++; $display("FAIL rmid_resume got=%h/%0d exp=6699/1", {lnk.x_data, lnk.y_data}, lnk.sample_cnt);
    end
  endtask

  task automatic test_saturate();
    int sv0;
    half = 1;
    send_header();
    sv0 = sv_count;
    for (int i = 0; i < 2100; i++) send_byte(i[7:0], ~i[7:0]);
    tick(6);
    total++; if (lnk.sample_cnt !== 11'd2047) begin bad++; $display("FAIL sat_cnt got=%0d exp=2047", lnk.sample_cnt); end
    total++; if (sv_count - sv0 != 2100) begin bad++; $display("FAIL sat_pulses got=%0d exp=2100", sv_count - sv0); end
    // Last byte index 2099 = 0x833, low byte 0x33.
    total++; if ({lnk.x_data, lnk.y_data} !== 16'h33CC) begin
      bad++; $display("FAIL sat_last got=%h exp=33cc", {lnk.x_data, lnk.y_data});
    end
    half = 3;
  endtask

  initial begin
    lnk.scl = 1'b1; lnk.x = 1'b1; lnk.y = 1'b1;
    test_reset();
    test_basic();
    test_addr_err();
    test_ctrl_err();
    test_stop();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
